// File: rtl/uart_tx_drain.sv
// UART transmitter that drains words from an upstream FIFO and sends them as
// start / WIDTH data bits (LSB first) / stop frames, back-to-back when data is waiting.
module uart_tx_drain #(
    parameter int CLKS_PER_BIT = 174,
    parameter int WIDTH        = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_valid,
    input  logic [WIDTH-1:0] fifo_data,
    output logic             fifo_pop,
    output logic             tx,
    output logic             busy
);

    localparam int              IDXW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [IDXW-1:0] IDX_LAST  = IDXW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [15:0]      baud_cnt;
    logic [15:0]      baud_next;
    logic [IDXW-1:0]  bit_idx;
    logic [IDXW-1:0]  idx_next;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_next;
    logic             tx_next;
    logic             busy_next;
    logic             baud_end;

    assign baud_end = (baud_cnt == BAUD_LAST);

    // A word is taken only when the line is free or the current stop bit is ending.
    assign fifo_pop = fifo_valid && !reset &&
                      ((state == IDLE) || ((state == STOP) && baud_end));

    always_comb begin
        state_next = state;
        baud_next  = baud_cnt;
        idx_next   = bit_idx;
        shift_next = shift_reg;

        case (state)
            IDLE: begin
                if (fifo_pop) begin
                    state_next = START;
                    baud_next  = '0;
                    shift_next = fifo_data;
                end
            end
            START: begin
                if (baud_end) begin
                    state_next = DATA;
                    baud_next  = '0;
                    idx_next   = '0;
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_next  = '0;
                    shift_next = shift_reg >> 1;
                    if (bit_idx == IDX_LAST) begin
                        state_next = STOP;
                    end else begin
                        idx_next = bit_idx + 1'b1;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_next = '0;
                    if (fifo_pop) begin
                        state_next = START;
                        shift_next = fifo_data;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_cnt + 16'd1;
                end
            end
            default: begin
                state_next = IDLE;
                baud_next  = '0;
            end
        endcase

        // tx and busy are registered from the upcoming state so the line moves one cycle after a pop.
        tx_next = 1'b1;
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shift_next[0];
            default: tx_next = 1'b1;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= '0;
            shift_reg <= '0;
            tx        <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            baud_cnt  <= baud_next;
            bit_idx   <= idx_next;
            shift_reg <= shift_next;
            tx        <= tx_next;
            busy      <= busy_next;
        end
    end

endmodule

// File: doc/uart_tx_drain.md
UART_TX_DRAIN -- requirements
Module: uart_tx_drain

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 174, clock cycles per serial bit (20 MHz / 115200 baud); legal range 2..65535.
REQ-002 The block SHALL have parameter WIDTH, default 8, data bits per frame.
REQ-003 clk  input  1  system clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 fifo_valid  input  1  high when the upstream FIFO output element holds a word.
REQ-006 fifo_data  input  WIDTH  word at the upstream FIFO output element; meaningful only while fifo_valid=1.
REQ-007 fifo_pop  output  1  one-cycle accept strobe to the FIFO; the word on fifo_data is consumed in any cycle where fifo_pop=1.
REQ-008 tx  output  1  serial line, 8N1-style framing (WIDTH data bits), idle high, registered.
REQ-009 busy  output  1  high while a frame is in progress (START, DATA, STOP states), registered.

Function
REQ-010 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-011 A baud counter SHALL count 0..CLKS_PER_BIT-1; each state except IDLE SHALL last exactly CLKS_PER_BIT cycles per bit.
REQ-012 fifo_pop SHALL be combinational: 1 iff fifo_valid=1 and reset=0 and (state=IDLE, or state=STOP with baud counter=CLKS_PER_BIT-1).
REQ-013 In any cycle where fifo_pop=1, fifo_data SHALL be captured into a WIDTH-bit shift register, and the FSM SHALL enter START with the baud counter at 0.
REQ-014 In IDLE with fifo_valid=0, the FSM SHALL remain in IDLE with tx=1, busy=0, fifo_pop=0.
REQ-015 In START, tx SHALL be 0; at baud count CLKS_PER_BIT-1, the FSM SHALL go to DATA with bit index 0.
REQ-016 In DATA, tx SHALL equal shift register bit 0 (LSB first). At each bit end, the register SHALL shift right one place and the bit index SHALL increment. After bit index WIDTH-1 ends, the FSM SHALL go to STOP.
REQ-017 In STOP, tx SHALL be 1. At the stop-bit end, the FSM SHALL go to START if fifo_pop=1 (back-to-back), else to IDLE.
REQ-018 Latency: when fifo_pop=1 in cycle N, tx SHALL first be 0 in cycle N+1, and busy SHALL be 1 from cycle N+1.
REQ-019 A frame SHALL occupy exactly (WIDTH+2)*CLKS_PER_BIT cycles. With fifo_valid held high, consecutive frames SHALL have zero idle gap.
REQ-020 fifo_data and fifo_valid changes during START/DATA/STOP SHALL have no effect on the frame in progress. fifo_pop SHALL stay 0 in those states except as given in REQ-012.
REQ-021 fifo_pop SHALL never be asserted for two consecutive cycles.

Reset
REQ-022 While reset=1, the block SHALL hold: state=IDLE, tx=1, busy=0, fifo_pop=0, baud counter=0, bit index=0, shift register=0.
REQ-023 Reset asserted mid-frame SHALL abort the frame: tx=1 from the next edge, and the captured word SHALL be discarded, not re-popped.
REQ-024 On the first cycle after reset deasserts, the block SHALL be in IDLE, and fifo_pop SHALL follow REQ-012 that same cycle.

Verification (CLKS_PER_BIT=4, WIDTH=8)
REQ-025 Single byte: fifo_valid=1, fifo_data=8'hA5 for one cycle from IDLE -> fifo_pop=1 that cycle; tx=0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; busy=1 for 40 cycles, then 0.
REQ-026 Back-to-back: fifo_valid held 1, data 8'h00 then 8'hFF -> second fifo_pop exactly 40 cycles after the first; the second frame's start bit immediately follows the first frame's stop bit.
REQ-027 Empty FIFO: fifo_valid=0 for 100 cycles after reset -> tx=1, busy=0, fifo_pop=0 throughout.
REQ-028 Mid-frame reset: reset=1 for one cycle during DATA bit 3 -> tx=1 and busy=0 from next edge; with fifo_valid=0, no frame resumes.
REQ-029 Data stability: pop 8'h3C, then change fifo_data every cycle during the frame -> serialized bits are still 0,0,1,1,1,1,0,0.
REQ-030 Reset with pending data: reset=1 while fifo_valid=1 -> fifo_pop=0 while reset=1; fifo_pop=1 on the first cycle after deassertion.
